// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-mapped RV32I load/store unit with data memory and I/O registers
module load_store_unit #(
    parameter int DMEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  funct3,
    input  logic [31:0] io_sw_i,
    input  logic [31:0] io_keys_i,
    output logic [31:0] o_ld_data,
    output logic [31:0] io_ledr_o,
    output logic [31:0] io_ledg_o,
    output logic [31:0] io_lcd_o,
    output logic [31:0] io_hex0_o,
    output logic [31:0] io_hex1_o,
    output logic [31:0] io_hex2_o,
    output logic [31:0] io_hex3_o,
    output logic [31:0] io_hex4_o,
    output logic [31:0] io_hex5_o,
    output logic [31:0] io_hex6_o,
    output logic [31:0] io_hex7_o
);

    localparam int WORDS = DMEM_BYTES / 4;
    localparam int AW    = $clog2(WORDS);
    localparam int NREGS = 11;

    logic [31:0] mem [WORDS];
    logic [31:0] out_regs [NREGS];
    logic [31:0] sw_q, keys_q;

    logic        dmem_hit, io_hit, sw_hit, keys_hit;
    logic [3:0]  reg_idx;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] word;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Region base 0x0800 is aligned to the memory size, so low address bits index directly.
    assign dmem_hit = ({16'b0, addr} >= 32'h0000_0800) &&
                      ({16'b0, addr} <  32'h0000_0800 + 32'(DMEM_BYTES));
    assign reg_idx  = addr[5:2];
    assign io_hit   = (addr[15:6] == 10'h070) && (reg_idx < 4'd11);
    assign sw_hit   = (addr[15:2] == 14'h0780);
    assign keys_hit = (addr[15:2] == 14'h0781);

    // Store lanes: low two funct3 bits give the size; 011/110/111 enable nothing.
    always_comb begin
        be    = 4'b0000;
        wdata = i_st_data;
        casez (funct3)
            3'b?00: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{i_st_data[7:0]}};
            end
            3'b?01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_st_data[15:0]}};
            end
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NREGS; i++) out_regs[i] <= '0;
            sw_q   <= '0;
            keys_q <= '0;
        end else begin
            sw_q   <= io_sw_i;
            keys_q <= io_keys_i;
            if (i_lsu_wren && io_hit) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) out_regs[reg_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Data memory has no reset; stores are still suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (!rst_n && i_lsu_wren && dmem_hit) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_comb begin
        word = '0;
        if (dmem_hit)      word = mem[addr[AW+1:2]];
        else if (io_hit)   word = out_regs[reg_idx];
        else if (sw_hit)   word = sw_q;
        else if (keys_hit) word = keys_q;
    end

    always_comb begin
        rbyte = word[7:0];
        case (addr[1:0])
            2'd0: rbyte = word[7:0];
            2'd1: rbyte = word[15:8];
            2'd2: rbyte = word[23:16];
            2'd3: rbyte = word[31:24];
        endcase
        rhalf = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        o_ld_data = '0;
        case (funct3)
            3'b000:  o_ld_data = {{24{rbyte[7]}}, rbyte};
            3'b001:  o_ld_data = {{16{rhalf[15]}}, rhalf};
            3'b010:  o_ld_data = word;
            3'b100:  o_ld_data = {24'b0, rbyte};
            3'b101:  o_ld_data = {16'b0, rhalf};
            default: o_ld_data = '0;
        endcase
    end

    assign io_ledr_o = out_regs[0];
    assign io_ledg_o = out_regs[1];
    assign io_hex0_o = out_regs[2];
    assign io_hex1_o = out_regs[3];
    assign io_hex2_o = out_regs[4];
    assign io_hex3_o = out_regs[5];
    assign io_hex4_o = out_regs[6];
    assign io_hex5_o = out_regs[7];
    assign io_hex6_o = out_regs[8];
    assign io_hex7_o = out_regs[9];
    assign io_lcd_o  = out_regs[10];

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [31:0] i_st_data;
    logic        i_lsu_wren;
    logic [2:0]  funct3;
    logic [31:0] io_sw_i;
    logic [31:0] io_keys_i;
    logic [31:0] o_ld_data;
    logic [31:0] io_ledr_o, io_ledg_o, io_lcd_o;
    logic [31:0] io_hex0_o, io_hex1_o, io_hex2_o, io_hex3_o;
    logic [31:0] io_hex4_o, io_hex5_o, io_hex6_o, io_hex7_o;

    load_store_unit #(.DMEM_BYTES(2048)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .i_st_data(i_st_data),
        .i_lsu_wren(i_lsu_wren), .funct3(funct3), .io_sw_i(io_sw_i),
        .io_keys_i(io_keys_i), .o_ld_data(o_ld_data),
        .io_ledr_o(io_ledr_o), .io_ledg_o(io_ledg_o), .io_lcd_o(io_lcd_o),
        .io_hex0_o(io_hex0_o), .io_hex1_o(io_hex1_o), .io_hex2_o(io_hex2_o),
        .io_hex3_o(io_hex3_o), .io_hex4_o(io_hex4_o), .io_hex5_o(io_hex5_o),
        .io_hex6_o(io_hex6_o), .io_hex7_o(io_hex7_o)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [2:0]  f;
        logic [31:0] e;
    } ld_t;

    sb_t sb[$];
    int  passed = 0;
    int  total  = 0;

    task automatic do_store(input logic [15:0] a, input logic [31:0] d, input logic [2:0] f);
        @(negedge clk);
        addr = a; i_st_data = d; funct3 = f; i_lsu_wren = 1'b1;
        @(posedge clk);
        #1;
        i_lsu_wren = 1'b0;
    endtask

    task automatic issue_load(input string n, input logic [15:0] a, input logic [2:0] f,
                              input logic [31:0] e);
        addr = a; funct3 = f; i_lsu_wren = 1'b0;
        sb.push_back('{n, e});
    endtask

    task automatic test_reset;
        sb_t s;
        rst_n = 1'b1;
        io_sw_i = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        total++; if (io_ledr_o !== 32'h0) $display("FAIL rst_ledr got %h exp 0", io_ledr_o); else passed++;
        total++; if (io_hex7_o !== 32'h0) $display("FAIL rst_hex7 got %h exp 0", io_hex7_o); else passed++;
        total++; if (io_lcd_o  !== 32'h0) $display("FAIL rst_lcd got %h exp 0", io_lcd_o); else passed++;
        issue_load("rst_sw_buf", 16'h1E00, F_W, 32'h0);
        #1; s = sb.pop_front();
        total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        io_sw_i = 32'h0;
    endtask

    task automatic test_dmem;
        ld_t t[$];
        sb_t s;
        do_store(16'h0800, 32'hDEAD_BEEF, F_W);
        t.push_back('{"lw_0800", 16'h0800, F_W,   32'hDEAD_BEEF});
        t.push_back('{"lb_0800", 16'h0800, F_B,   32'hFFFF_FFEF});
        t.push_back('{"lbu_0803", 16'h0803, F_BU, 32'h0000_00DE});
        t.push_back('{"lh_0802", 16'h0802, F_H,   32'hFFFF_DEAD});
        t.push_back('{"lhu_0802", 16'h0802, F_HU, 32'h0000_DEAD});
        t.push_back('{"lb_0801", 16'h0801, F_B,   32'hFFFF_FFBE});
        t.push_back('{"ld_bad_f3", 16'h0800, F_BAD, 32'h0});
        foreach (t[i]) begin
            issue_load(t[i].name, t[i].a, t[i].f, t[i].e);
            #1; s = sb.pop_front();
            total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
        end
        t.delete();
        do_store(16'h0801, 32'h0000_0055, F_B);
        do_store(16'h0800, 32'h0000_0000, F_BAD);
        do_store(16'h0FFC, 32'h8000_0001, F_W);
        t.push_back('{"sb_lane1", 16'h0800, F_W, 32'hDEAD_55EF});
        t.push_back('{"lw_top",   16'h0FFC, F_W, 32'h8000_0001});
        t.push_back('{"lb_0fff",  16'h0FFF, F_B, 32'hFFFF_FF80});
        foreach (t[i]) begin
            issue_load(t[i].name, t[i].a, t[i].f, t[i].e);
            #1; s = sb.pop_front();
            total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
        end
    endtask

    task automatic test_leds;
        sb_t s;
        do_store(16'h1C00, 32'h1234_5678, F_W);
        total++; if (io_ledr_o !== 32'h1234_5678) $display("FAIL ledr_sw got %h exp 12345678", io_ledr_o); else passed++;
        do_store(16'h1C01, 32'h0000_00AB, F_B);
        total++; if (io_ledr_o !== 32'h1234_AB78) $display("FAIL ledr_sb got %h exp 1234ab78", io_ledr_o); else passed++;
        total++; if (io_ledg_o !== 32'h0) $display("FAIL ledg_idle got %h exp 0", io_ledg_o); else passed++;
        total++; if (io_hex0_o !== 32'h0) $display("FAIL hex0_idle got %h exp 0", io_hex0_o); else passed++;
        total++; if (io_lcd_o  !== 32'h0) $display("FAIL lcd_idle got %h exp 0", io_lcd_o); else passed++;
        issue_load("lb_1c01", 16'h1C01, F_B, 32'hFFFF_FFAB);
        #1; s = sb.pop_front();
        total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
        issue_load("lhu_1c02", 16'h1C02, F_HU, 32'h0000_1234);
        #1; s = sb.pop_front();
        total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
    endtask

    task automatic test_hex_lcd;
        sb_t s;
        do_store(16'h1C0A, 32'h0000_BEEF, F_H);
        do_store(16'h1C24, 32'h0000_007F, F_W);
        do_store(16'h1C28, 32'h0000_A5A5, F_W);
        total++; if (io_hex0_o !== 32'hBEEF_0000) $display("FAIL hex0_sh got %h exp beef0000", io_hex0_o); else passed++;
        total++; if (io_hex7_o !== 32'h0000_007F) $display("FAIL hex7_sw got %h exp 0000007f", io_hex7_o); else passed++;
        total++; if (io_lcd_o  !== 32'h0000_A5A5) $display("FAIL lcd_sw got %h exp 0000a5a5", io_lcd_o); else passed++;
        total++; if (io_hex1_o !== 32'h0) $display("FAIL hex1_idle got %h exp 0", io_hex1_o); else passed++;
        issue_load("lw_hex7", 16'h1C24, F_W, 32'h0000_007F);
        #1; s = sb.pop_front();
        total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
    endtask

    task automatic test_inputs;
        ld_t t[$];
        sb_t s;
        @(negedge clk);
        io_sw_i = 32'hAAAA_AAAA;
        io_keys_i = 32'hBBBB_BBBB;
        @(posedge clk); #1;
        do_store(16'h1E00, 32'h1111_1111, F_W);
        t.push_back('{"lw_sw",    16'h1E00, F_W,  32'hAAAA_AAAA});
        t.push_back('{"lw_keys",  16'h1E04, F_W,  32'hBBBB_BBBB});
        t.push_back('{"lb_keys",  16'h1E04, F_B,  32'hFFFF_FFBB});
        t.push_back('{"lhu_keys", 16'h1E06, F_HU, 32'h0000_BBBB});
        foreach (t[i]) begin
            issue_load(t[i].name, t[i].a, t[i].f, t[i].e);
            #1; s = sb.pop_front();
            total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
        end
    endtask

    task automatic test_unmapped;
        ld_t t[$];
        sb_t s;
        do_store(16'h0500, 32'hCAFE_BABE, F_W);
        total++; if (io_ledr_o !== 32'h1234_AB78) $display("FAIL unm_ledr got %h exp 1234ab78", io_ledr_o); else passed++;
        total++; if (io_ledg_o !== 32'h0) $display("FAIL unm_ledg got %h exp 0", io_ledg_o); else passed++;
        t.push_back('{"lw_0500", 16'h0500, F_W, 32'h0});
        t.push_back('{"lw_0800_keep", 16'h0800, F_W, 32'hDEAD_55EF});
        t.push_back('{"lw_1c2c", 16'h1C2C, F_W, 32'h0});
        t.push_back('{"lw_1e08", 16'h1E08, F_W, 32'h0});
        t.push_back('{"lw_1000", 16'h1000, F_W, 32'h0});
        foreach (t[i]) begin
            issue_load(t[i].name, t[i].a, t[i].f, t[i].e);
            #1; s = sb.pop_front();
            total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
        end
    endtask

    task automatic test_back_to_back;
        sb_t s;
        @(negedge clk);
        addr = 16'h0804; funct3 = F_W; i_st_data = 32'h1111_1111; i_lsu_wren = 1'b1;
        @(posedge clk); #1;
        i_st_data = 32'h2222_2222;
        sb.push_back('{"pre_edge_view", 32'h1111_1111});
        s = sb.pop_front();
        total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
        @(posedge clk); #1;
        i_lsu_wren = 1'b0;
        issue_load("b2b_second", 16'h0804, F_W, 32'h2222_2222);
        #1; s = sb.pop_front();
        total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
    endtask

    task automatic test_reset_mid;
        sb_t s;
        do_store(16'h1C14, 32'h0000_0005, F_W);
        total++; if (io_hex3_o !== 32'h5) $display("FAIL hex3_set got %h exp 5", io_hex3_o); else passed++;
        #2;
        rst_n = 1'b1;
        #1;
        total++; if (io_hex3_o !== 32'h0) $display("FAIL hex3_async_rst got %h exp 0", io_hex3_o); else passed++;
        total++; if (io_ledr_o !== 32'h0) $display("FAIL ledr_async_rst got %h exp 0", io_ledr_o); else passed++;
        addr = 16'h1C00; funct3 = F_W; i_st_data = 32'h7777_7777; i_lsu_wren = 1'b1;
        @(posedge clk); #1;
        i_lsu_wren = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (io_ledr_o !== 32'h0) $display("FAIL store_in_rst got %h exp 0", io_ledr_o); else passed++;
        issue_load("lw_0800_after_rst", 16'h0800, F_W, 32'hDEAD_55EF);
        #1; s = sb.pop_front();
        total++; if (o_ld_data !== s.exp) $display("FAIL %s got %h exp %h", s.name, o_ld_data, s.exp); else passed++;
    endtask

    initial begin
        rst_n = 1'b1; addr = '0; i_st_data = '0; i_lsu_wren = 1'b0;
        funct3 = F_W; io_sw_i = '0; io_keys_i = '0;
        test_reset();
        test_dmem();
        test_leds();
        test_hex_lcd();
        test_inputs();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-mapped load/store unit for the single-cycle RISC-V core.
- Decodes a 16-bit byte address onto three regions: a 2 KiB data memory, output peripheral registers (LEDs, LCD, 8 seven-segment displays) and input buffers (switches, keys).
- Performs RV32I byte, halfword and word loads and stores, with sign or zero extension on loads.

Parameters:
DMEM_BYTES, 2048, data memory size in bytes (word-organised, DMEM_BYTES/4 words)

Ports:
clk  input  1  system clock; all writes occur on the rising edge
rst_n  input  1  asynchronous reset, active-high (asserted at 1, despite the codebase name)
addr  input  16  byte address of the access
i_st_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
i_lsu_wren  input  1  store enable; 1 = store at next rising edge, 0 = load
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
io_sw_i  input  32  switch inputs
io_keys_i  input  32  push-button inputs
o_ld_data  output  32  load result, extended to 32 bits
io_ledr_o  output  32  red LED register
io_ledg_o  output  32  green LED register
io_lcd_o  output  32  LCD register
io_hex0_o..io_hex7_o  output  32 each  seven-segment registers 0..7

Behaviour:
Address map (inclusive ranges):
- 0x0800-0x0FFF: data memory, read/write.
- 0x1C00 LEDR, 0x1C04 LEDG, 0x1C08..0x1C24 HEX0..HEX7 (4-byte stride), 0x1C28 LCD: read/write.
- 0x1E00 switches, 0x1E04 keys: read-only; stores to these addresses are ignored.
- Any other address: loads return 0, stores are ignored with no side effects.

Stores:
- On the rising clk edge when i_lsu_wren=1 and the address maps to a writable location.
- Byte lane select: addr[1:0] for bytes, addr[1] for halfwords; word stores ignore addr[1:0].
- SB writes only the selected byte; SH writes the selected 2 bytes; SW writes all 4.
- Unselected bytes are unchanged. The same byte-enable rules apply to peripheral registers.
- funct3 values 011, 110 and 111 on a store: no write.

Loads:
- Combinational: o_ld_data follows addr, funct3 and current storage with no clock.
- The addressed word is selected first, then byte/half lane extraction uses the same lane rules as stores.
- B and H sign-extend; BU and HU zero-extend; W returns the full word.
- Illegal funct3 returns 0.
- During a store cycle o_ld_data still shows the pre-edge contents.
- Output registers read back their current value.
- Input buffers: io_sw_i and io_keys_i are registered every clock (reset 0); reads return the registered value.

Reset:
- While rst_n=1, all output registers and input buffer registers are 0, asynchronously.
- Stores are blocked during reset.
- Data memory contents are not reset and are undefined until written.
- Reset asserted mid-operation clears the registers immediately; a pending store is dropped.

Outputs:
- io_* outputs are driven directly from their registers. A change is visible after the storing edge (one-cycle latency).

Test Plan:
- Data memory: SW 0xDEADBEEF at 0x0800, wren pulsed for one edge, then load W at 0x0800 -> o_ld_data = 0xDEADBEEF. Then LB at 0x0800 -> 0xFFFFFFEF, LBU at 0x0803 -> 0x000000DE, LH at 0x0802 -> 0xFFFFDEAD.
- LEDs: SW 0x12345678 at 0x1C00 -> io_ledr_o = 0x12345678 after the edge. SB 0xAB at 0x1C01 -> 0x1234AB78. Other output registers remain 0.
- Switches: io_sw_i = 0xAAAAAAAA held ≥1 cycle, LW 0x1E00 -> 0xAAAAAAAA. A store to 0x1E00 has no effect.
- Keys: io_keys_i = 0xBBBBBBBB, LW 0x1E04 -> 0xBBBBBBBB.
- Unmapped: SW 0xCAFEBABE at 0x0500 -> no register or memory changes; LW 0x0500 -> 0x00000000.
- Reset: write HEX3 (0x1C14) = 0x5, then assert rst_n=1 between clock edges -> io_hex3_o = 0 immediately. A store with wren=1 during reset is not performed.
